sigmoid_lut_arbiter: RTL and testbench

Shares one synchronous sigmoid lookup ROM between `N_REQ` neuron nodes in the node-function layer. Each node presents a 22-bit accumulated pre-activation `y`. The block arbitrates round-robin, decodes `y` into sign, overflow and table address, and issues the ROM read, or bypasses the ROM on overflow. Results return in order, tagged with the requester id, through a credit-limited response FIFO that tolerates downstream backpressure.

---
 rtl/sigmoid_pkg.sv | 26 ++
 rtl/sigmoid_lut_arbiter_rsp_fifo.sv | 51 +++++
 rtl/sigmoid_lut_arbiter.sv | 131 +++++++++++++
 tb/tb_sigmoid_lut_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// rtl/sigmoid_pkg.sv - pre-activation field layout and saturation constants for the sigmoid LUT arbiter
package sigmoid_pkg;

  localparam int Y_W      = 22;
  localparam int ADDR_W   = 9;
  localparam int SIGN_BIT = 21;
  localparam int OVF_HI   = 20;
  localparam int OVF_LO   = 14;
  localparam int ADDR_HI  = 13;
  localparam int ADDR_LO  = 5;

  // Saturated 1.0 is all ones at the activation width (widths up to 32)
  function automatic logic [31:0] SAT_HI(input int dw);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < dw) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] SAT_LO(input int dw);
    return (dw > 0) ? 32'd0 : 32'd0;
  endfunction

endpackage

// File: rtl/sigmoid_lut_arbiter_rsp_fifo.sv
// rtl/sigmoid_lut_arbiter_rsp_fifo.sv - synchronous response FIFO exposing its occupancy count
module rsp_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_rd, do_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A write into a full FIFO is accepted when the head leaves in the same cycle
  assign do_rd = rd_en_i & (count_q != '0);
  assign do_wr = wr_en_i & ((count_q != CW'(DEPTH)) | do_rd);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/sigmoid_lut_arbiter.sv
// rtl/sigmoid_lut_arbiter.sv - round-robin sharing of one sigmoid ROM with credit-limited in-order responses
module sigmoid_lut_arbiter
  import sigmoid_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*Y_W-1:0] req_y,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rom_en,
  output logic [ADDR_W:0]      rom_addr,
  input  logic [DW-1:0]        rom_dout,
  output logic                 rsp_valid,
  output logic [IW-1:0]        rsp_id,
  output logic [DW-1:0]        rsp_data,
  input  logic                 rsp_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 3);

  logic [IW-1:0]     rr_q, rr_d, gnt_idx;
  logic              gnt_found, credit_ok, accept;
  logic [N_REQ-1:0]  gnt_onehot;
  logic [Y_W-1:0]    gnt_y;
  logic              dec_sign, dec_ovf;
  logic [ADDR_W-1:0] dec_addr;
  logic [CW-1:0]     fifo_count;
  logic [OW-1:0]     occ;

  logic              a_valid_q, a_sign_q, a_ovf_q;
  logic [IW-1:0]     a_id_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic              b_valid_q, b_sign_q, b_ovf_q;
  logic [IW-1:0]     b_id_q;

  logic [DW-1:0]     push_data;
  logic [IW+DW-1:0]  fifo_head;
  logic              fifo_empty;

  // Every accepted request owns a FIFO slot from acceptance until it is popped
  assign occ       = OW'(a_valid_q) + OW'(b_valid_q) + OW'(fifo_count);
  assign credit_ok = (occ < OW'(FIFO_DEPTH));

  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

  assign accept = rstn & gnt_found & credit_ok;

  always_comb begin
    gnt_onehot = '0;
    if (accept) gnt_onehot[gnt_idx] = 1'b1;
  end
  assign req_ready = gnt_onehot;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
  end

  assign gnt_y    = req_y[int'(gnt_idx)*Y_W +: Y_W];
  assign dec_sign = gnt_y[SIGN_BIT];
  assign dec_addr = gnt_y[ADDR_HI:ADDR_LO];
  assign dec_ovf  = dec_sign ? (~&gnt_y[OVF_HI:OVF_LO] | ~|gnt_y[ADDR_HI:ADDR_LO])
                             : |gnt_y[OVF_HI:OVF_LO];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q      <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      a_valid_q <= accept;
      b_valid_q <= a_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_id_q   <= gnt_idx;
      a_sign_q <= dec_sign;
      a_ovf_q  <= dec_ovf;
      a_addr_q <= dec_addr;
    end
    b_id_q   <= a_id_q;
    b_sign_q <= a_sign_q;
    b_ovf_q  <= a_ovf_q;
  end

  assign rom_en   = a_valid_q & ~a_ovf_q;
  assign rom_addr = rom_en ? {a_sign_q, a_addr_q} : '0;

  assign push_data = b_ovf_q ? (b_sign_q ? DW'(SAT_LO(DW)) : DW'(SAT_HI(DW))) : rom_dout;

  rsp_fifo #(
    .W     (IW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (b_valid_q),
    .wr_data_i ({b_id_q, push_data}),
    .rd_en_i   (rsp_ready),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_id    = rsp_valid ? fifo_head[IW+DW-1:DW] : '0;
  assign rsp_data  = rsp_valid ? fifo_head[DW-1:0] : '0;

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// tb/tb_sigmoid_lut_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_sigmoid_lut_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          rdy;
  } item_t;

  logic          clk;
  logic          rstn;
  logic [N-1:0]  req_valid;
  logic [N*22-1:0] req_y;
  logic [N-1:0]  req_ready;
  logic          rom_en;
  logic [9:0]    rom_addr;
  logic [15:0]   rom_dout;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          rsp_ready;

  int          checks;
  int          failures;
  int          cyc;
  int          rr_m;
  int          acc_obs;
  logic        exp_rom_en;
  logic [9:0]  exp_rom_addr;
  item_t       q[$];
  logic        pend [N];
  logic [21:0] yv [N];
  logic [21:0] bnd [7];

  sigmoid_lut_arbiter #(.N_REQ(N), .DW(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input int a);
    return 16'((a * 40503) ^ 23100);
  endfunction

  initial rom_dout = 16'h0;
  always @(posedge clk) if (rom_en) rom_dout <= rom_fn(int'(rom_addr));

  // Reference: signed value range decides saturation, otherwise ROM[sign*512 + y/32 mod 512]
  function automatic int signed_y(input logic [21:0] y);
    return y[21] ? int'(y) - 4194304 : int'(y);
  endfunction

  function automatic logic y_ovf(input logic [21:0] y);
    int v;
    v = signed_y(y);
    return (v >= 16384) || (v < -16352);
  endfunction

  function automatic int y_index(input logic [21:0] y);
    return (y[21] ? 512 : 0) + ((int'(y) / 32) % 512);
  endfunction

  function automatic logic [15:0] exp_act(input logic [21:0] y);
    int v;
    v = signed_y(y);
    if (v >= 16384) return 16'hFFFF;
    if (v < -16352) return 16'h0000;
    return rom_fn(y_index(y));
  endfunction

  function automatic logic [21:0] rand_y();
    logic [21:0] y;
    case ($urandom_range(0, 3))
      0:       y = {8'h00, 14'($urandom)};
      1:       y = {8'hFF, 14'($urandom)};
      2:       y = 22'($urandom);
      default: y = bnd[$urandom_range(0, 6)];
    endcase
    return y;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend[i];
      req_y[22*i +: 22]   = yv[i];
    end
  endtask

  task automatic cycle();
    int          gid;
    int          idx;
    logic [N-1:0] exp_rdy;
    logic        exp_v;
    item_t       it;
    @(negedge clk);
    gid     = -1;
    exp_rdy = '0;
    if (rstn && q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr_m + k) % N;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    end
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("rom_en", 32'(rom_en), 32'(exp_rom_en));
    check_eq("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
    exp_v = (q.size() > 0) && (q[0].rdy <= cyc);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check_eq("rsp_id", 32'(rsp_id), 32'(q[0].id));
      check_eq("rsp_data", 32'(rsp_data), 32'(q[0].data));
    end
    if ((req_valid & req_ready) != '0) acc_obs++;
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      rr_m         = 0;
      exp_rom_en   = 1'b0;
      exp_rom_addr = '0;
    end else begin
      if (exp_v && rsp_ready) void'(q.pop_front());
      if (gid >= 0) begin
        it.id   = gid;
        it.data = exp_act(yv[gid]);
        it.rdy  = cyc + 3;
        q.push_back(it);
        rr_m         = (gid + 1) % N;
        exp_rom_en   = !y_ovf(yv[gid]);
        exp_rom_addr = exp_rom_en ? 10'(y_index(yv[gid])) : 10'd0;
        pend[gid]    = 1'b0;
      end else begin
        exp_rom_en   = 1'b0;
        exp_rom_addr = '0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    apply();
    cycle();
  endtask

  task automatic raise_all();
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        pend[i] = 1'b1;
        yv[i]   = rand_y();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; rr_m = 0; acc_obs = 0;
    exp_rom_en = 1'b0; exp_rom_addr = '0;
    bnd[0] = 22'h003FFF; bnd[1] = 22'h004000; bnd[2] = 22'h3FC000; bnd[3] = 22'h3FC01F;
    bnd[4] = 22'h3FC020; bnd[5] = 22'h3FFFFF; bnd[6] = 22'h000000;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; yv[i] = '0; end
    rstn = 1'b0; rsp_ready = 1'b1;
    apply();
    repeat (2) @(posedge clk);
    #1;
    step();
    rstn = 1'b1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    idle(1);

    // Directed decode cases, one node at a time
    pend[0] = 1'b1; yv[0] = 22'h000400; idle(4);
    pend[1] = 1'b1; yv[1] = 22'h004000; idle(4);
    pend[2] = 1'b1; yv[2] = 22'h3FC000; idle(4);
    pend[3] = 1'b1; yv[3] = 22'h3FC020; idle(4);

    // All nodes valid continuously with an always-ready sink
    for (int i = 0; i < 40; i++) begin raise_all(); step(); end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    idle(6);

    // Backpressure: credit caps accepts at the FIFO depth
    rsp_ready = 1'b0; acc_obs = 0;
    for (int i = 0; i < 10; i++) begin raise_all(); step(); end
    check_eq("bp_accepts", 32'(acc_obs), 32'(DEPTH));
    acc_obs = 0;
    rsp_ready = 1'b1; raise_all(); step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin raise_all(); step(); end
    check_eq("bp_one_pop_one_accept", 32'(acc_obs), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    idle(10);

    // Reset with A, B and FIFO occupied
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin raise_all(); step(); end
    rstn = 1'b0; step();
    rstn = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    step();
    check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("post_rst_rom_addr", 32'(rom_addr), 32'd0);
    pend[2] = 1'b1; yv[2] = rand_y();
    pend[3] = 1'b1; yv[3] = rand_y();
    apply();
    #1;
    check_eq("post_rst_first_grant", 32'(req_ready), 32'h4);
    cycle();
    rsp_ready = 1'b1;
    idle(8);

    // Randomized traffic with random backpressure and rare resets
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          yv[i]   = rand_y();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rstn      = ($urandom_range(0, 499) != 0);
      step();
    end
    rstn = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int n = 0; n < 50 && q.size() > 0; n++) step();
    idle(2);
    check_eq("drained_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
